jb_dl_dfe_tdm_s2p_align: RTL and testbench
==========================================

Name: jb_dl_dfe_tdm_s2p_align

Overview:
- Receives the 4x-rate TDM antenna-interleaved stream (tuser = antenna index, one sample per antenna per 1x period).
- Deserialises it into N_ANTENNAS parallel, group-aligned sample words, presented together with a one-cycle valid strobe.
- Acts as the inverse of the UL parallel-to-serial/FIFO path: it sits at the DL DFE front end, ahead of the per-antenna integer-delay and CFR chains.
- Also supervises TDM ordering: hunt/lock, gap timeout and a saturating error counter.

Parameters:
- N_ANTENNAS, 4, antennas interleaved per TDM group (power of 2, 2..8).
- PRECISION, 16, bits per I or Q component; sample is {Q,I} = 2*PRECISION bits.
- USR_ID_BW, 2, tuser width; must equal clog2(N_ANTENNAS).
- LOCK_GROUPS, 4, consecutive good groups required to assert lock (1..15).
- GAP_MAX, 3, max consecutive idle (tvalid=0) cycles allowed inside a group.

Ports:
- clk_4x  in  1  491.52 MHz clock; the only clock.
- rst_4x  in  1  asynchronous, active-high reset.
- s_tvalid  in  1  TDM input beat valid.
- s_tdata  in  2*PRECISION  {Q,I} sample.
- s_tuser  in  USR_ID_BW  antenna index of beat.
- s_tready  out  1  input ready; 0 in reset, 1 from the first clock after reset release.
- err_clr  in  1  synchronous clear of err_cnt and err_sticky.
- tvalid_s2p  out  N_ANTENNAS  group-valid strobe, all bits identical.
- tdata_s2p  out  [N_ANTENNAS-1:0][2*PRECISION]  aligned samples, index = antenna.
- lock  out  1  stream aligned.
- err_cnt  out  16  saturating count of alignment errors.
- err_sticky  out  1  set on any error, cleared by err_clr.

Behaviour:
- Reset (async assert, sync release):
  - tvalid_s2p=0, tdata_s2p=0, lock=0, err_cnt=0, err_sticky=0, s_tready=0.
  - State HUNT, expected index exp=0, gap counter=0, good-group counter=0.
- Accepted beat = s_tvalid & s_tready. Beats with s_tvalid=0 are ignored, except for gap counting.
- HUNT:
  - Accepted beat with tuser=0 → store into slot 0, exp=1, go to COLLECT.
  - Accepted beat with tuser≠0 → discard; no error counted.
- COLLECT:
  - Accepted beat with tuser==exp → store into slot exp, exp=exp+1, gap=0.
  - If exp was N_ANTENNAS-1, the group is complete: go to COMPLETE handling and set exp=0.
  - Idle cycle (s_tvalid=0) → gap+1. When gap reaches GAP_MAX+1 → error, go to HUNT, discard partial group.
  - Accepted beat with tuser≠exp → error, discard partial group. If that beat's tuser=0, it starts a new group (slot 0, exp=1, stay in COLLECT); otherwise go to HUNT.
- Group complete:
  - Cycle after the last beat is accepted: tdata_s2p updated with all slots; tvalid_s2p = all-ones for exactly 1 cycle.
  - Latency: 1 clk from the tuser=N-1 beat to the strobe.
  - tdata_s2p holds its value until the next complete group. A partial group never alters tdata_s2p.
  - Next group may start on the cycle directly after the last beat (back-to-back groups: strobe every N_ANTENNAS cycles).
- Lock:
  - Good-group counter increments per complete group, saturating at LOCK_GROUPS.
  - lock=1 on the cycle the counter reaches LOCK_GROUPS (same cycle as that group's strobe).
  - Any error → lock=0 and good counter=0 on the next cycle.
  - Strobes are emitted regardless of lock.
- Error:
  - err_cnt+1, saturating at 0xFFFF; err_sticky=1.
  - err_clr and a simultaneous error in the same cycle → result err_cnt=1, err_sticky=1 (error wins over clear).
- Idle in HUNT never counts gaps. Reset asserted mid-group clears everything immediately; no strobe is emitted for the partial group.

Test Plan:
- Continuous stream, N=4, tuser 0,1,2,3 repeating, tdata=antenna*0x1000+group → first strobe 1 clk after first tuser=3. tdata_s2p[2]=0x2000. lock rises on the 4th strobe, err_cnt=0.
- Start mid-group (first beats tuser=2,3) then aligned → those 2 beats are discarded with no error; the first strobe carries the group starting at the next tuser=0.
- Locked stream, inject tuser sequence 0,1,3 → err_cnt=1, err_sticky=1, lock=0 next cycle, no strobe, tdata_s2p unchanged. Relock after 4 further good groups.
- Gap test, GAP_MAX=3: 3 idle cycles between tuser 1 and 2 → group completes normally. 4 idle cycles → error, HUNT, err_cnt increments.
- Out-of-order beat tuser=0 at exp=2 → err_cnt=1, and that beat starts a new group. The following 1,2,3 produces a strobe whose slot 0 equals that beat's data.
- err_cnt preloaded to 0xFFFF via 65535 forced errors, one more error → stays 0xFFFF. err_clr alone → 0 next cycle. err_clr together with an error → err_cnt=1. Async reset mid-group → all outputs 0 immediately.

Source files
------------

// File: rtl/jb_dl_dfe_tdm_s2p_align.sv
// ---------------------------------------------------------------------------
// jb_dl_dfe_tdm_s2p_align
//
// DL DFE front end: deserialises a 4x-rate TDM antenna-interleaved stream
// (s_tuser = antenna index) into N_ANTENNAS parallel, group-aligned samples.
// A complete group (indices 0..N-1 in order) is published on tdata_s2p with
// a one-cycle all-ones tvalid_s2p strobe, one clock after its last beat.
// Ordering is supervised: hunt for index 0, collect in order, time out on
// long idle gaps inside a group, count errors (saturating) and report lock
// after LOCK_GROUPS consecutive good groups.
//
// Ports
//   clk_4x      4x-rate clock, the only clock
//   rst_4x      asynchronous active-high reset
//   s_tvalid    input beat valid
//   s_tdata     input sample {Q,I}
//   s_tuser     antenna index of the beat
//   s_tready    input ready (low during reset, high from first clock after)
//   err_clr     synchronous clear of err_cnt / err_sticky
//   tvalid_s2p  group-valid strobe, all bits identical
//   tdata_s2p   aligned samples, index = antenna
//   lock        stream aligned
//   err_cnt     saturating alignment-error count
//   err_sticky  set on any error, cleared by err_clr
// ---------------------------------------------------------------------------
module jb_dl_dfe_tdm_s2p_align #(
    parameter int N_ANTENNAS  = 4,
    parameter int PRECISION   = 16,
    parameter int USR_ID_BW   = 2,
    parameter int LOCK_GROUPS = 4,
    parameter int GAP_MAX     = 3
) (
    input  logic                                    clk_4x,
    input  logic                                    rst_4x,
    input  logic                                    s_tvalid,
    input  logic [2*PRECISION-1:0]                  s_tdata,
    input  logic [USR_ID_BW-1:0]                    s_tuser,
    output logic                                    s_tready,
    input  logic                                    err_clr,
    output logic [N_ANTENNAS-1:0]                   tvalid_s2p,
    output logic [N_ANTENNAS-1:0][2*PRECISION-1:0]  tdata_s2p,
    output logic                                    lock,
    output logic [15:0]                             err_cnt,
    output logic                                    err_sticky
);

    localparam int SW    = 2 * PRECISION;
    localparam int GAP_W = $clog2(GAP_MAX + 2);

    localparam logic [USR_ID_BW-1:0] LAST_IDX    = USR_ID_BW'(N_ANTENNAS - 1);
    localparam logic [USR_ID_BW-1:0] IDX_ONE     = USR_ID_BW'(1);
    localparam logic [GAP_W-1:0]     GAP_LAST_OK = GAP_W'(GAP_MAX);
    localparam logic [GAP_W-1:0]     GAP_ONE     = GAP_W'(1);
    localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_GROUPS);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [USR_ID_BW-1:0]   exp_reg, exp_next;
    logic [GAP_W-1:0]       gap_reg, gap_next;
    logic                   ready_reg;
    logic [3:0]             good_reg, good_inc;

    logic                   accept;
    logic                   store_en;
    logic [USR_ID_BW-1:0]   store_idx;
    logic                   group_done;
    logic                   err_evt;

    logic [SW-1:0]                  slot_reg [N_ANTENNAS-1];
    logic [N_ANTENNAS-1:0][SW-1:0]  group_word;

    assign accept   = s_tvalid & ready_reg;
    assign s_tready = ready_reg;

    // ---------------- state register ----------------
    always_ff @(posedge clk_4x or posedge rst_4x) begin
        if (rst_4x) begin
            state_reg <= HUNT;
            exp_reg   <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            exp_reg   <= exp_next;
            gap_reg   <= gap_next;
        end
    end

    // ---------------- action decode (FSM outputs) ----------------
    // In COLLECT, exp_reg == 0 means "between groups": a finished group has
    // just been published and nothing of the next one has arrived, so idle
    // cycles there are not gaps inside a group.
    always_comb begin
        store_en   = 1'b0;
        store_idx  = '0;
        group_done = 1'b0;
        err_evt    = 1'b0;
        case (state_reg)
            HUNT: begin
                if (accept && s_tuser == '0) begin
                    store_en = 1'b1;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (s_tuser == exp_reg) begin
                        store_en   = 1'b1;
                        store_idx  = exp_reg;
                        group_done = (exp_reg == LAST_IDX);
                    end else begin
                        err_evt = 1'b1;
                        // an out-of-order index 0 restarts a group at once
                        store_en = (s_tuser == '0);
                    end
                end else if (!s_tvalid && exp_reg != '0 && gap_reg == GAP_LAST_OK) begin
                    err_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        exp_next   = exp_reg;
        gap_next   = gap_reg;
        case (state_reg)
            HUNT: begin
                gap_next = '0;
                if (store_en) begin
                    state_next = COLLECT;
                    exp_next   = IDX_ONE;
                end
            end
            COLLECT: begin
                if (accept) begin
                    gap_next = '0;
                    if (!err_evt) begin
                        exp_next = exp_reg + IDX_ONE;   // wraps to 0 after the last index
                    end else if (store_en) begin
                        exp_next = IDX_ONE;
                    end else begin
                        state_next = HUNT;
                        exp_next   = '0;
                    end
                end else if (!s_tvalid && exp_reg != '0) begin
                    if (err_evt) begin
                        state_next = HUNT;
                        exp_next   = '0;
                        gap_next   = '0;
                    end else begin
                        gap_next = gap_reg + GAP_ONE;
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // ---------------- sample slots ----------------
    // The last antenna is never stored: it is taken straight from the input
    // on the completing beat.
    genvar gi;
    generate
        for (gi = 0; gi < N_ANTENNAS - 1; gi++) begin : g_slot
            always_ff @(posedge clk_4x or posedge rst_4x) begin
                if (rst_4x) begin
                    slot_reg[gi] <= '0;
                end else if (store_en && store_idx == USR_ID_BW'(gi)) begin
                    slot_reg[gi] <= s_tdata;
                end
            end
            assign group_word[gi] = slot_reg[gi];
        end
    endgenerate

    assign group_word[N_ANTENNAS-1] = s_tdata;

    // ---------------- outputs, lock, errors ----------------
    assign good_inc = (good_reg == LOCK_TARGET) ? good_reg : good_reg + 4'd1;

    always_ff @(posedge clk_4x or posedge rst_4x) begin
        if (rst_4x) begin
            ready_reg  <= 1'b0;
            tvalid_s2p <= '0;
            tdata_s2p  <= '0;
            good_reg   <= '0;
            lock       <= 1'b0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            ready_reg  <= 1'b1;
            tvalid_s2p <= {N_ANTENNAS{group_done}};
            if (group_done) begin
                tdata_s2p <= group_word;
            end

            if (err_evt) begin
                good_reg <= '0;
                lock     <= 1'b0;
            end else if (group_done) begin
                good_reg <= good_inc;
                lock     <= (good_inc == LOCK_TARGET);
            end

            // an error in the same cycle as err_clr wins: count restarts at 1
            if (err_evt) begin
                err_sticky <= 1'b1;
                if (err_clr) begin
                    err_cnt <= 16'd1;
                end else if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end else if (err_clr) begin
                err_cnt    <= '0;
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jb_dl_dfe_tdm_s2p_align.sv
module tb_jb_dl_dfe_tdm_s2p_align;

    localparam int N    = 4;
    localparam int P    = 16;
    localparam int LOCK = 4;
    localparam int GAPM = 3;

    logic                   clk_4x = 1'b0;
    logic                   rst_4x;
    logic                   s_tvalid;
    logic [2*P-1:0]         s_tdata;
    logic [1:0]             s_tuser;
    logic                   s_tready;
    logic                   err_clr;
    logic [N-1:0]           tvalid_s2p;
    logic [N-1:0][2*P-1:0]  tdata_s2p;
    logic                   lock;
    logic [15:0]            err_cnt;
    logic                   err_sticky;

    int checks = 0;
    int errors = 0;

    jb_dl_dfe_tdm_s2p_align #(
        .N_ANTENNAS(N), .PRECISION(P), .USR_ID_BW(2),
        .LOCK_GROUPS(LOCK), .GAP_MAX(GAPM)
    ) dut (
        .clk_4x(clk_4x), .rst_4x(rst_4x),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser),
        .s_tready(s_tready), .err_clr(err_clr),
        .tvalid_s2p(tvalid_s2p), .tdata_s2p(tdata_s2p),
        .lock(lock), .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    always #5 clk_4x = ~clk_4x;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the group being assembled as a queue of samples; its length is
    // the index the next beat must carry.
    logic [31:0] mq[$];
    logic [31:0] m_out [N];
    bit m_hunt, m_lock, m_ready, m_strobe, m_sticky;
    int m_gap, m_good, m_errs;

    task automatic model_reset();
        mq.delete();
        m_hunt = 1; m_gap = 0; m_good = 0; m_lock = 0; m_ready = 0;
        m_strobe = 0; m_sticky = 0; m_errs = 0;
        for (int i = 0; i < N; i++) m_out[i] = '0;
    endtask

    task automatic model_step();
        bit err;
        err = 0;
        m_strobe = 0;
        if (s_tvalid && m_ready) begin
            if (m_hunt) begin
                if (s_tuser == 0) begin
                    mq.push_back(s_tdata);
                    m_hunt = 0;
                end
            end else if (int'(s_tuser) == mq.size()) begin
                mq.push_back(s_tdata);
                m_gap = 0;
                if (mq.size() == N) begin
                    for (int i = 0; i < N; i++) m_out[i] = mq[i];
                    mq.delete();
                    m_strobe = 1;
                end
            end else begin
                err = 1;
                m_gap = 0;
                mq.delete();
                if (s_tuser == 0) mq.push_back(s_tdata);
                else m_hunt = 1;
            end
        end else if (!s_tvalid && !m_hunt && mq.size() != 0) begin
            m_gap++;
            if (m_gap > GAPM) begin
                err = 1;
                m_hunt = 1;
                mq.delete();
                m_gap = 0;
            end
        end
        if (err) begin
            m_good = 0;
            m_lock = 0;
        end else if (m_strobe) begin
            if (m_good < LOCK) m_good++;
            m_lock = (m_good == LOCK);
        end
        if (err) begin
            m_errs = err_clr ? 1 : (m_errs < 65535 ? m_errs + 1 : 65535);
            m_sticky = 1;
        end else if (err_clr) begin
            m_errs = 0;
            m_sticky = 0;
        end
        m_ready = 1;
    endtask

    // ---------------- per-cycle compare ----------------
    always begin
        logic [N-1:0][2*P-1:0] exp_data;
        @(posedge clk_4x or posedge rst_4x);
        if (rst_4x) model_reset();
        else model_step();
        #1;
        for (int i = 0; i < N; i++) exp_data[i] = m_out[i];
        chk("cyc_tvalid", 128'(tvalid_s2p), 128'(m_strobe ? {N{1'b1}} : {N{1'b0}}));
        chk("cyc_tdata", 128'(tdata_s2p), 128'(exp_data));
        chk("cyc_lock", 128'(lock), 128'(m_lock));
        chk("cyc_err_cnt", 128'(err_cnt), 128'(m_errs));
        chk("cyc_err_sticky", 128'(err_sticky), 128'(m_sticky));
        chk("cyc_tready", 128'(s_tready), 128'(m_ready));
        if (tvalid_s2p[0])
            $display("group t=%0t d0=%h d1=%h d2=%h d3=%h lock=%0b err_cnt=%0d",
                     $time, tdata_s2p[0], tdata_s2p[1], tdata_s2p[2], tdata_s2p[3], lock, err_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic beat(input int u, input logic [31:0] d);
        @(negedge clk_4x);
        s_tvalid = 1'b1;
        s_tuser  = 2'(u);
        s_tdata  = d;
    endtask

    task automatic idle();
        @(negedge clk_4x);
        s_tvalid = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk_4x);
        #1;
    endtask

    task automatic group(input int g);
        for (int a = 0; a < N; a++) beat(a, 32'(a * 32'h1000 + g));
    endtask

    initial begin
        rst_4x = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk_4x);
        chk("rst_tvalid", 128'(tvalid_s2p), 128'h0);
        chk("rst_tdata", 128'(tdata_s2p), 128'h0);
        chk("rst_lock", 128'(lock), 128'h0);
        chk("rst_err_cnt", 128'(err_cnt), 128'h0);
        chk("rst_tready", 128'(s_tready), 128'h0);
        rst_4x = 1'b0;
        idle();

        // continuous aligned stream
        for (int g = 0; g < 6; g++) begin
            group(g);
            after_edge();
            chk("t1_strobe", 128'(tvalid_s2p), 128'hF);
            if (g == 0) chk("t1_first_slot2", 128'(tdata_s2p[2]), 128'h2000);
            if (g == 2) chk("t1_lock_before", 128'(lock), 128'h0);
            if (g == 3) chk("t1_lock_4th", 128'(lock), 128'h1);
        end
        chk("t1_err_cnt", 128'(err_cnt), 128'h0);

        // misordered group while locked
        beat(0, 32'h0000_0006); beat(1, 32'h0000_1006); beat(3, 32'h0000_3006);
        after_edge();
        chk("t3_err_cnt", 128'(err_cnt), 128'h1);
        chk("t3_sticky", 128'(err_sticky), 128'h1);
        chk("t3_lock", 128'(lock), 128'h0);
        chk("t3_no_strobe", 128'(tvalid_s2p), 128'h0);
        chk("t3_hold", 128'(tdata_s2p[3]), 128'h3005);
        for (int g = 7; g < 11; g++) begin
            group(g);
            after_edge();
            if (g == 9) chk("t3_relock_3rd", 128'(lock), 128'h0);
            if (g == 10) chk("t3_relock_4th", 128'(lock), 128'h1);
        end

        // gap tolerance and gap timeout
        beat(0, 32'h0A); beat(1, 32'h1A);
        repeat (3) idle();
        beat(2, 32'h2A); beat(3, 32'h3A);
        after_edge();
        chk("gap3_strobe", 128'(tvalid_s2p), 128'hF);
        chk("gap3_slot2", 128'(tdata_s2p[2]), 128'h2A);
        beat(0, 32'h0B); beat(1, 32'h1B);
        repeat (4) idle();
        after_edge();
        chk("gap4_err_cnt", 128'(err_cnt), 128'h2);
        chk("gap4_lock", 128'(lock), 128'h0);

        // clear alone
        @(negedge clk_4x); err_clr = 1'b1;
        after_edge();
        chk("clr_err_cnt", 128'(err_cnt), 128'h0);
        chk("clr_sticky", 128'(err_sticky), 128'h0);
        @(negedge clk_4x); err_clr = 1'b0;

        // out-of-order index 0 restarts a group
        beat(0, 32'h111); beat(1, 32'h222); beat(0, 32'hABCD_0000);
        after_edge();
        chk("ooo_err_cnt", 128'(err_cnt), 128'h1);
        beat(1, 32'h1C); beat(2, 32'h2C); beat(3, 32'h3C);
        after_edge();
        chk("ooo_strobe", 128'(tvalid_s2p), 128'hF);
        chk("ooo_slot0", 128'(tdata_s2p[0]), 128'hABCD_0000);

        // saturate: the first 0 opens a group, each further 0 is an error
        beat(0, 32'h5);
        for (int k = 0; k < 65534; k++) beat(0, 32'h5);
        after_edge();
        chk("sat_reach", 128'(err_cnt), 128'hFFFF);
        beat(0, 32'h5);
        after_edge();
        chk("sat_hold", 128'(err_cnt), 128'hFFFF);

        // clear together with an error
        @(negedge clk_4x); err_clr = 1'b1; s_tvalid = 1'b1; s_tuser = 2'd0;
        after_edge();
        chk("clr_err_err_cnt", 128'(err_cnt), 128'h1);
        chk("clr_err_sticky", 128'(err_sticky), 128'h1);
        @(negedge clk_4x); err_clr = 1'b0; s_tuser = 2'd1; s_tdata = 32'h77;

        // asynchronous reset in the middle of a group
        beat(2, 32'h88);
        @(negedge clk_4x); s_tvalid = 1'b0;
        #2 rst_4x = 1'b1;
        #1;
        chk("arst_tdata", 128'(tdata_s2p), 128'h0);
        chk("arst_err_cnt", 128'(err_cnt), 128'h0);
        chk("arst_sticky", 128'(err_sticky), 128'h0);
        chk("arst_tready", 128'(s_tready), 128'h0);
        @(negedge clk_4x); rst_4x = 1'b0;
        idle();
        beat(3, 32'h99);
        group(20);
        after_edge();
        chk("post_rst_strobe", 128'(tvalid_s2p), 128'hF);
        chk("post_rst_slot1", 128'(tdata_s2p[1]), 128'h1014);
        idle();
        after_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
